// File: rtl/fetch_pkg.sv
// Shared widths, reset default and state encoding for the fetch PC unit.
package fetch_pkg;

    localparam int PC_W        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_RUN        = 2'd0,
        FETCH_WAIT_MEM   = 2'd1,
        FETCH_REDIR_PEND = 2'd2
    } fetch_state_e;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Pair of 32-bit saturating event counters observing the fetch unit.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic        i_miss,
    output logic [31:0] o_redirect_cnt,
    output logic [31:0] o_miss_cyc_cnt
);

    logic [31:0] r_redirect_cnt;
    logic [31:0] r_miss_cyc_cnt;

    // Counters stick at all-ones instead of wrapping back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_cnt <= '0;
            r_miss_cyc_cnt <= '0;
        end else begin
            if (i_redirect && (r_redirect_cnt != 32'hFFFF_FFFF))
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            if (i_miss && (r_miss_cyc_cnt != 32'hFFFF_FFFF))
                r_miss_cyc_cnt <= r_miss_cyc_cnt + 32'd1;
        end
    end

    assign o_redirect_cnt = r_redirect_cnt;
    assign o_miss_cyc_cnt = r_miss_cyc_cnt;

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator feeding the predictor, I-cache and IF/ID register.
// Define FETCH_PERF_CNT_EN to add redirect and miss-cycle counters.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pc_out,
    output logic            fetch_req_out,
    input  logic            pred_taken_in,
    input  logic [PC_W-1:0] pred_target_in,
    input  logic            icache_ready_in,
    input  logic            stall_in,
    input  logic            redirect_in,
    input  logic [PC_W-1:0] redirect_pc_in,
    output logic            if_valid_out,
    output logic [PC_W-1:0] if_pc_out,
    output logic            if_pred_taken_out,
    output logic [PC_W-1:0] if_pred_target_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     redirect_cnt_out,
    output logic [31:0]     miss_cyc_cnt_out
`endif
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] r_pend_pc;
    logic [PC_W-1:0] w_pend_pc_nxt;
    logic            r_fetch_req;
    logic            r_if_valid;
    logic            w_if_valid_nxt;
    logic [PC_W-1:0] r_if_pc;
    logic [PC_W-1:0] w_if_pc_nxt;
    logic            r_if_pred_taken;
    logic            w_if_pred_taken_nxt;
    logic [PC_W-1:0] r_if_pred_target;
    logic [PC_W-1:0] w_if_pred_target_nxt;

    logic            w_ready;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_next_pc;

    // No request is outstanding in the first cycle after reset, so a ready then is not a fetch.
    assign w_ready   = icache_ready_in && r_fetch_req;
    assign w_seq_pc  = r_pc + PC_W'(INSTR_BYTES);
    assign w_next_pc = pred_taken_in ? align_pc(pred_target_in) : w_seq_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= FETCH_RUN;
            r_pc             <= RESET_PC;
            r_pend_pc        <= '0;
            r_fetch_req      <= 1'b0;
            r_if_valid       <= 1'b0;
            r_if_pc          <= '0;
            r_if_pred_taken  <= 1'b0;
            r_if_pred_target <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_pc             <= w_pc_nxt;
            r_pend_pc        <= w_pend_pc_nxt;
            r_fetch_req      <= 1'b1;
            r_if_valid       <= w_if_valid_nxt;
            r_if_pc          <= w_if_pc_nxt;
            r_if_pred_taken  <= w_if_pred_taken_nxt;
            r_if_pred_target <= w_if_pred_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_pc_nxt             = r_pc;
        w_pend_pc_nxt        = r_pend_pc;
        w_if_valid_nxt       = r_if_valid;
        w_if_pc_nxt          = r_if_pc;
        w_if_pred_taken_nxt  = r_if_pred_taken;
        w_if_pred_target_nxt = r_if_pred_target;

        case (r_state)
            FETCH_RUN, FETCH_WAIT_MEM: begin
                if (redirect_in) begin
                    w_if_valid_nxt = 1'b0;
                    // An outstanding miss cannot be aborted, so the target is parked until it returns.
                    if (w_ready || (stall_in && (r_state == FETCH_RUN))) begin
                        w_pc_nxt    = redirect_pc_in;
                        w_state_nxt = FETCH_RUN;
                    end else begin
                        w_pend_pc_nxt = redirect_pc_in;
                        w_state_nxt   = FETCH_REDIR_PEND;
                    end
                end else if (stall_in) begin
                    w_state_nxt = r_state;
                end else if (w_ready) begin
                    w_if_valid_nxt       = 1'b1;
                    w_if_pc_nxt          = r_pc;
                    w_if_pred_taken_nxt  = pred_taken_in;
                    w_if_pred_target_nxt = pred_target_in;
                    w_pc_nxt             = w_next_pc;
                    w_state_nxt          = FETCH_RUN;
                end else begin
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = FETCH_WAIT_MEM;
                end
            end

            FETCH_REDIR_PEND: begin
                w_if_valid_nxt = 1'b0;
                if (w_ready) begin
                    w_pc_nxt    = redirect_in ? redirect_pc_in : r_pend_pc;
                    w_state_nxt = FETCH_RUN;
                end else if (redirect_in) begin
                    w_pend_pc_nxt = redirect_pc_in;
                end
            end

            default: begin
                w_state_nxt = FETCH_RUN;
            end
        endcase
    end

    assign pc_out             = r_pc;
    assign fetch_req_out      = r_fetch_req;
    assign if_valid_out       = r_if_valid;
    assign if_pc_out          = r_if_pc;
    assign if_pred_taken_out  = r_if_pred_taken;
    assign if_pred_target_out = r_if_pred_target;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .i_redirect     (redirect_in),
        .i_miss         (r_fetch_req && !icache_ready_in),
        .o_redirect_cnt (redirect_cnt_out),
        .o_miss_cyc_cnt (miss_cyc_cnt_out)
    );
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
IF-stage PC generator directly upstream of the branch predictor. It drives the fetch PC to the predictor and I-cache, and consumes the predictor's same-cycle taken/target prediction to pick the next PC. It accepts misprediction redirects from EX and loads the IF/ID register with the PC plus its prediction, so EX can resolve it later. It holds a redirect that arrives while an I-cache miss cannot be aborted.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
pc_out  out  32  current fetch PC; drives predictor read port and I-cache address
fetch_req_out  out  1  I-cache request valid
pred_taken_in  in  1  predictor taken, combinational on pc_out
pred_target_in  in  32  predictor target, combinational on pc_out
icache_ready_in  in  1  instruction for pc_out available this cycle; held high while pc_out is stable
stall_in  in  1  hazard-unit stall of PC and IF/ID
redirect_in  in  1  EX misprediction correction
redirect_pc_in  in  32  corrected PC
if_valid_out  out  1  IF/ID entry valid
if_pc_out  out  32  IF/ID PC
if_pred_taken_out  out  1  IF/ID captured prediction
if_pred_target_out  out  32  IF/ID captured target

Behaviour:
- Reset (rst=1 at an edge):
  - pc_out=RESET_PC, fetch_req_out=0, if_valid_out=0, if_pc_out=0, if_pred_taken_out=0, if_pred_target_out=0, state=RUN, pend_pc=0.
  - fetch_req_out goes to 1 on the first edge after reset and stays 1.
  - Reset mid-miss or mid-pending drops everything.
- Next-PC computation:
  - next_pc = pred_taken_in ? {pred_target_in[31:2],2'b00} : pc_out+4.
  - The addition is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- States: RUN, WAIT_MEM, REDIR_PEND.
- RUN:
  - redirect_in && (icache_ready_in || stall_in): pc_out<=redirect_pc_in, if_valid_out<=0, stay RUN.
  - redirect_in && !icache_ready_in && !stall_in: pend_pc<=redirect_pc_in, if_valid_out<=0, go REDIR_PEND.
  - No redirect, stall_in=1: pc_out and IF/ID hold.
  - No redirect, icache_ready_in=1, stall_in=0 (advance): if_valid_out<=1, if_pc_out<=pc_out, if_pred_*<=pred inputs, pc_out<=next_pc.
  - No redirect, icache_ready_in=0, stall_in=0: go WAIT_MEM. pc_out holds and if_valid_out<=0.
- WAIT_MEM:
  - Same rules as RUN.
  - Advancing returns to RUN.
  - A redirect with icache_ready_in=0 goes to REDIR_PEND, whether or not stall_in is asserted.
- REDIR_PEND:
  - pc_out holds and fetch_req_out stays 1.
  - if_valid_out=0 throughout.
  - A new redirect_in overwrites pend_pc (latest wins).
  - On icache_ready_in=1, the returned instruction is discarded, pc_out<=pend_pc (or redirect_pc_in if a redirect arrives that same cycle), and the state goes to RUN. stall_in is ignored here.
- Priority: rst > redirect_in > stall_in > advance. A flush always clears if_valid_out, even under stall.
- Latency:
  - Redirect to new pc_out is 1 cycle when no miss is outstanding.
  - Prediction to pc_out is 1 cycle (zero-bubble taken branch).

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs redirect_cnt_out[31:0] and miss_cyc_cnt_out[31:0].
  - redirect_cnt_out counts edges with redirect_in=1.
  - miss_cyc_cnt_out counts edges with fetch_req_out=1 && icache_ready_in=0.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - PC_W=32
  - INSTR_BYTES=4
  - DEFAULT_RESET_PC
  - state encoding FETCH_RUN=2'd0, FETCH_WAIT_MEM=2'd1, FETCH_REDIR_PEND=2'd2
- One natural sub-module, fetch_perf_cnt: a saturating counter pair, instantiated only under FETCH_PERF_CNT_EN.

Test Plan:
- Sequential fetch: reset then release, ready=1, no prediction -> pc_out sequence 0,4,8,C; if_valid_out=1 from the second post-reset edge onward with if_pc_out lagging one cycle.
- Predicted taken: pc_out=32'h10, pred_taken_in=1, pred_target_in=32'h41 -> next pc_out=32'h40; if_pc_out=32'h10, if_pred_taken_out=1, if_pred_target_out=32'h41.
- Stall plus redirect: stall_in=1 for 3 cycles holds pc_out=32'h20; redirect_in=1 with redirect_pc_in=32'h100 during the stall -> pc_out=32'h100 next cycle and if_valid_out=0.
- Redirect during miss: ready=0 at pc_out=32'h30, redirect to 32'h200, then a second redirect to 32'h300 two cycles later, then ready=1 -> pc_out stays 32'h30 until ready, then goes to 32'h300; no valid IF/ID entry with if_pc_out=32'h30 is produced.
- Wrap: pc_out=32'hFFFF_FFFC with ready=1 -> pc_out=32'h0.
- Reset in REDIR_PEND: rst=1 for one cycle -> pc_out=RESET_PC, state RUN, pend_pc discarded. With FETCH_PERF_CNT_EN defined, both counters read 0.
